// File: rtl/eth_pkt_pkg.sv
// Shared definitions for the UDP frame generator: FSM states, fixed header
// constants and the IPv4 header checksum helper.
package eth_pkt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CSUM,
        PREAMBLE,
        SFD,
        HEADER,
        PAYLOAD,
        PAD,
        FCS,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam int          HDR_BYTES      = 42;
    localparam int          MIN_PAYLOAD    = 18;
    localparam int          PREAMBLE_LEN   = 7;

    // Ones-complement of the ones-complement sum of the ten IPv4 header words.
    function automatic logic [15:0] ip_csum(input logic [9:0][15:0] words);
        logic [19:0] sum;
        sum = '0;
        for (int i = 0; i < 10; i++) sum = sum + {4'h0, words[i]};
        sum = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
        sum = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 (reflected, poly 0xEDB88320). The register holds
// the running value; the transmitted FCS is its complement.
module eth_crc32_d8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || init) crc <= 32'hFFFF_FFFF;
        else if (en)     crc <= crc_step(crc, data);
    end

endmodule

// File: rtl/udp_frame_gen.sv
// Ethernet/IPv4/UDP frame generator on a GMII byte stream.
// Define UDP_FRAME_GEN_IPCSUM_EN to fill in the IPv4 header checksum; otherwise it is sent as 0x0000.
module udp_frame_gen
    import eth_pkt_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 1472,
    parameter int         IFG_BYTES   = 12,
    parameter logic [7:0] IP_TTL      = 8'h40
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [47:0] i_dst_mac,
    input  logic [47:0] i_src_mac,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    input  logic [15:0] i_src_port,
    input  logic [15:0] i_dst_port,
    input  logic [10:0] i_len,
    output logic        o_pl_rd,
    input  logic [7:0]  i_pl_data,
    output logic [7:0]  o_data,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] HDR_LAST = 11'(HDR_BYTES - 1);
    // The IDLE and CSUM cycles also leave o_tx_en low, so the IFG state is
    // shortened by two to keep the on-wire gap at exactly IFG_BYTES.
    localparam logic [10:0] IFG_CYC  = (IFG_BYTES > 3) ? 11'(IFG_BYTES - 2) : 11'd1;

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt;
    logic [47:0] dst_mac, src_mac;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port;
    logic [10:0] len, pad_len;
    logic [15:0] ip_id, hdr_csum, csum_calc;
    logic [15:0] ip_len, udp_len;
    logic [HDR_BYTES-1:0][7:0] hdr;
    logic [5:0]  hdr_idx;
    logic [7:0]  byte_nxt;
    logic        tx_nxt, done_nxt, crc_init, crc_en;
    logic [31:0] crc;

    assign ip_len  = 16'(len) + 16'd28;
    assign udp_len = 16'(len) + 16'd8;
    assign pad_len = (len < MIN_LEN) ? MIN_LEN - len : 11'd0;
    assign hdr_idx = 6'(HDR_LAST) - cnt[5:0];
    assign o_busy  = (state != IDLE);

    assign hdr = {dst_mac, src_mac, ETHERTYPE_IPV4,
                  8'h45, 8'h00, ip_len,
                  ip_id, 16'h0000, IP_TTL, IP_PROTO_UDP, hdr_csum,
                  src_ip, dst_ip,
                  src_port, dst_port, udp_len, 16'h0000};

`ifdef UDP_FRAME_GEN_IPCSUM_EN
    logic [9:0][15:0] ip_words;
    assign ip_words  = {16'h4500, ip_len, ip_id, 16'h0000, IP_TTL, IP_PROTO_UDP,
                        16'h0000, src_ip, dst_ip};
    assign csum_calc = ip_csum(ip_words);
`else
    assign csum_calc = 16'h0000;
`endif

    eth_crc32_d8 u_crc (
        .clk  (i_clk),
        .rst  (i_rst),
        .init (crc_init),
        .en   (crc_en),
        .data (byte_nxt),
        .crc  (crc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            o_data   <= 8'h00;
            o_tx_en  <= 1'b0;
            o_done   <= 1'b0;
            ip_id    <= '0;
            hdr_csum <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            o_data  <= byte_nxt;
            o_tx_en <= tx_nxt;
            o_done  <= done_nxt;
            if (state == CSUM) hdr_csum <= csum_calc;
            if (done_nxt)      ip_id    <= ip_id + 16'd1;
        end
    end

    // Frame fields are frozen at acceptance so later input changes cannot corrupt the frame.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_start) begin
            dst_mac  <= i_dst_mac;
            src_mac  <= i_src_mac;
            src_ip   <= i_src_ip;
            dst_ip   <= i_dst_ip;
            src_port <= i_src_port;
            dst_port <= i_dst_port;
            len      <= (i_len > MAX_LEN) ? MAX_LEN : i_len;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        byte_nxt  = 8'h00;
        tx_nxt    = 1'b0;
        done_nxt  = 1'b0;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        o_pl_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = CSUM;
                    cnt_nxt   = '0;
                    crc_init  = 1'b1;
                end
            end
            CSUM: begin
                state_nxt = PREAMBLE;
                cnt_nxt   = '0;
            end
            PREAMBLE: begin
                tx_nxt   = 1'b1;
                byte_nxt = PREAMBLE_BYTE;
                if (cnt == PRE_LAST) begin
                    state_nxt = SFD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            SFD: begin
                tx_nxt    = 1'b1;
                byte_nxt  = SFD_BYTE;
                state_nxt = HEADER;
                cnt_nxt   = '0;
            end
            HEADER: begin
                tx_nxt   = 1'b1;
                crc_en   = 1'b1;
                byte_nxt = hdr[hdr_idx];
                if (cnt == HDR_LAST) begin
                    state_nxt = (len != 11'd0) ? PAYLOAD : PAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            PAYLOAD: begin
                tx_nxt   = 1'b1;
                crc_en   = 1'b1;
                o_pl_rd  = 1'b1;
                byte_nxt = i_pl_data;
                if (cnt == len - 11'd1) begin
                    state_nxt = (pad_len != 11'd0) ? PAD : FCS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            PAD: begin
                tx_nxt = 1'b1;
                crc_en = 1'b1;
                if (cnt == pad_len - 11'd1) begin
                    state_nxt = FCS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            FCS: begin
                tx_nxt = 1'b1;
                case (cnt[1:0])
                    2'd0:    byte_nxt = ~crc[7:0];
                    2'd1:    byte_nxt = ~crc[15:8];
                    2'd2:    byte_nxt = ~crc[23:16];
                    default: byte_nxt = ~crc[31:24];
                endcase
                if (cnt[1:0] == 2'd3) begin
                    done_nxt  = 1'b1;
                    state_nxt = IFG;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            IFG: begin
                if (cnt == IFG_CYC - 11'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_udp_frame_gen.sv
// Bench for udp_frame_gen: a byte-level frame model feeds an expected-stream
// queue that a single monitor checks every cycle, plus directed literal checks.
module tb_udp_frame_gen;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start;
    logic [47:0] i_dst_mac, i_src_mac;
    logic [31:0] i_src_ip, i_dst_ip;
    logic [15:0] i_src_port, i_dst_port;
    logic [10:0] i_len;
    logic        o_pl_rd;
    logic [7:0]  i_pl_data;
    logic [7:0]  o_data;
    logic        o_tx_en, o_busy, o_done;

    always #5 i_clk = ~i_clk;

    udp_frame_gen dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac),
        .i_src_ip(i_src_ip), .i_dst_ip(i_dst_ip),
        .i_src_port(i_src_port), .i_dst_port(i_dst_port),
        .i_len(i_len), .o_pl_rd(o_pl_rd), .i_pl_data(i_pl_data),
        .o_data(o_data), .o_tx_en(o_tx_en), .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct { logic [7:0] b; bit last; } exp_t;
    exp_t        exp_q[$];
    logic [7:0]  cur_frm[$];
    logic [7:0]  last_frm[$];
    int          total = 0, bad = 0;
    int          frames_done = 0, tx_total = 0, rd_total = 0, low_run = 0, gap_len = 0;
    int          pl_total = 0;
    bit          mon_en = 1'b0;
    logic        prev_tx = 1'b0;
    logic [15:0] model_id = 16'h0;

    // Payload source: a running byte counter, advanced on each consumed byte.
    assign i_pl_data = 8'(pl_total + 1);
    always @(posedge i_clk) if (o_pl_rd === 1'b1) pl_total <= pl_total + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] crc_raw(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic push_exp(input logic [7:0] b, input bit last);
        exp_t e;
        e.b = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Expected frame built straight from the field layout of the frame format.
    task automatic build(input int len_req);
        logic [7:0]  f[$];
        logic [31:0] c;
        logic [15:0] ipl, udl;
        int          len;
        len = (len_req > 1472) ? 1472 : len_req;
        ipl = 16'(28 + len);
        udl = 16'(8 + len);
        for (int i = 5; i >= 0; i--) f.push_back(i_dst_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(i_src_mac[8*i +: 8]);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h45); f.push_back(8'h00);
        f.push_back(ipl[15:8]); f.push_back(ipl[7:0]);
        f.push_back(model_id[15:8]); f.push_back(model_id[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'h40); f.push_back(8'h11);
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 3; i >= 0; i--) f.push_back(i_src_ip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) f.push_back(i_dst_ip[8*i +: 8]);
        f.push_back(i_src_port[15:8]); f.push_back(i_src_port[7:0]);
        f.push_back(i_dst_port[15:8]); f.push_back(i_dst_port[7:0]);
        f.push_back(udl[15:8]); f.push_back(udl[7:0]);
        f.push_back(8'h00); f.push_back(8'h00);
`ifdef UDP_FRAME_GEN_IPCSUM_EN
        begin
            logic [19:0] s;
            logic [15:0] cs;
            s = '0;
            for (int k = 0; k < 10; k++) s = s + {4'h0, f[14+2*k], f[15+2*k]};
            s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
            s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
            cs = ~s[15:0];
            f[24] = cs[15:8];
            f[25] = cs[7:0];
        end
`endif
        for (int k = 0; k < len; k++) f.push_back(8'(pl_total + 1 + k));
        for (int k = len; k < 18; k++) f.push_back(8'h00);
        c = ~crc_raw(f);
        f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
        for (int k = 0; k < 7; k++) push_exp(8'h55, 1'b0);
        push_exp(8'hD5, 1'b0);
        foreach (f[i]) push_exp(f[i], i == f.size() - 1);
    endtask

    // Single compare process: every cycle the DUT is out of reset.
    always @(negedge i_clk) begin : mon
        exp_t e;
        if (mon_en && i_rst === 1'b0) begin
            if (o_tx_en === 1'b1) begin
                if (prev_tx !== 1'b1) begin
                    gap_len = low_run;
                    cur_frm.delete();
                end
                low_run = 0;
                tx_total++;
                cur_frm.push_back(o_data);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_byte: got %h while model expects no byte (t=%0t)", o_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", 32'(o_data), 32'(e.b));
                    chk("done_pulse", 32'(o_done), 32'(e.last));
                end
                if (o_done === 1'b1) begin
                    last_frm = cur_frm;
                    frames_done++;
                end
            end else begin
                low_run++;
                chk("idle_data_zero", 32'(o_data), 32'h0);
                chk("idle_no_done", 32'(o_done), 32'h0);
            end
            if (o_pl_rd === 1'b1) rd_total++;
            prev_tx = o_tx_en;
        end
    end

    task automatic load_a();
        i_dst_mac  = 48'hd8d38526c578;
        i_src_mac  = 48'h0023543c471b;
        i_src_ip   = 32'hC0A84D21;
        i_dst_ip   = 32'hC0A84DD9;
        i_src_port = 16'hC350;
        i_dst_port = 16'hC360;
    endtask

    task automatic scramble();
        i_dst_mac  = ~i_dst_mac;
        i_src_mac  = ~i_src_mac;
        i_src_ip   = ~i_src_ip;
        i_dst_ip   = ~i_dst_ip;
        i_src_port = ~i_src_port;
        i_dst_port = ~i_dst_port;
        i_len      = 11'h7FF;
    endtask

    task automatic start_frame(input int len, input bit lat);
        @(posedge i_clk); #1;
        load_a();
        i_len = 11'(len);
        build(len);
        model_id++;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        scramble();
        if (lat) begin
            @(negedge i_clk);
            chk("busy_after_start", 32'(o_busy), 32'h1);
            chk("tx_low_csum", 32'(o_tx_en), 32'h0);
            @(negedge i_clk);
            chk("tx_low_cycle1", 32'(o_tx_en), 32'h0);
            @(negedge i_clk);
            chk("first_preamble_tx", 32'(o_tx_en), 32'h1);
            chk("first_preamble_byte", 32'(o_data), 32'h55);
        end
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3000; i++) begin
            if (frames_done >= target) break;
            @(posedge i_clk);
        end
        chk("frame_completes", 32'(frames_done >= target), 32'h1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (o_busy === 1'b0) break;
            @(negedge i_clk);
        end
        chk("busy_falls", 32'(o_busy), 32'h0);
    endtask

    function automatic logic [15:0] rx16(input int idx);
        return {last_frm[idx], last_frm[idx+1]};
    endfunction

    function automatic logic [31:0] residue();
        logic [7:0] q[$];
        for (int i = 8; i < last_frm.size(); i++) q.push_back(last_frm[i]);
        return crc_raw(q);
    endfunction

    task automatic check_hdr_csum();
`ifdef UDP_FRAME_GEN_IPCSUM_EN
        logic [19:0] s;
        s = '0;
        for (int k = 0; k < 10; k++) s = s + {4'h0, rx16(22 + 2*k)};
        s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
        s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
        chk("ip_hdr_sum", 32'(s[15:0]), 32'hFFFF);
`else
        chk("ip_csum_zero", 32'(rx16(32)), 32'h0);
`endif
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  acc;
        logic [15:0] id_c;
        int          tx0, rd0, fd0;
        i_rst = 1'b1; i_start = 1'b0; i_len = '0;
        load_a();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_tx_en", 32'(o_tx_en), 32'h0);
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_pl_rd", 32'(o_pl_rd), 32'h0);
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        chk("model_crc_check_value", ~crc_raw(q), 32'hCBF43926);
        i_rst = 1'b0;
        mon_en = 1'b1;

        // Short padded frame, plus a start pulse while busy that must be ignored.
        tx0 = tx_total; rd0 = rd_total;
        start_frame(6, 1'b1);
        i_start = 1'b1; @(posedge i_clk); #1 i_start = 1'b0;
        wait_frames(1);
        chk("a_tx_cycles", 32'(tx_total - tx0), 32'd72);
        chk("a_pl_rd", 32'(rd_total - rd0), 32'd6);
        chk("a_ip_len", 32'(rx16(24)), 32'h0022);
        chk("a_udp_len", 32'(rx16(46)), 32'h000E);
        chk("a_ip_id", 32'(rx16(26)), 32'h0000);
        chk("a_last_payload", 32'(last_frm[55]), 32'h06);
        acc = 8'h00;
        for (int i = 56; i < 68; i++) acc = acc | last_frm[i];
        chk("a_pad_zero", 32'(acc), 32'h0);
        chk("a_fcs_residue", residue(), 32'hDEBB20E3);
        check_hdr_csum();
        wait_idle();

        // Maximum payload, then an over-length request clamped to the same size.
        for (int r = 0; r < 2; r++) begin
            tx0 = tx_total; rd0 = rd_total;
            start_frame(r == 0 ? 1472 : 2000, 1'b0);
            wait_frames(2 + r);
            chk("max_frame_bytes_after_sfd", 32'(tx_total - tx0 - 8), 32'd1518);
            chk("max_pl_rd", 32'(rd_total - rd0), 32'd1472);
            chk("max_ip_len", 32'(rx16(24)), 32'h05DC);
            chk("max_ip_id", 32'(rx16(26)), 32'(1 + r));
            chk("max_fcs_residue", residue(), 32'hDEBB20E3);
            wait_idle();
        end

        // Back-to-back frames: start held so it lands on the first IDLE cycle.
        start_frame(10, 1'b0);
        wait_frames(4);
        id_c = rx16(26);
        chk("c_ip_id", 32'(id_c), 32'h0003);
        #1;
        load_a();
        i_len = 11'd20;
        build(20);
        model_id++;
        i_start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_busy === 1'b0) break;
        end
        @(posedge i_clk); #1;
        i_start = 1'b0;
        scramble();
        wait_frames(5);
        chk("b2b_gap", 32'(gap_len), 32'd12);
        chk("b2b_id_step", 32'(rx16(26)), 32'(id_c + 16'd1));
        check_hdr_csum();
        wait_idle();

        // Reset while payload is streaming.
        rd0 = rd_total; fd0 = frames_done;
        start_frame(100, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (rd_total > rd0) break;
            @(negedge i_clk);
        end
        chk("e_payload_reached", 32'(rd_total > rd0), 32'h1);
        repeat (5) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        exp_q.delete();
        model_id = 16'h0;
        @(negedge i_clk);
        chk("mid_rst_tx_en", 32'(o_tx_en), 32'h0);
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        chk("mid_rst_pl_rd", 32'(o_pl_rd), 32'h0);
        chk("mid_rst_no_done", 32'(frames_done - fd0), 32'h0);

        // Zero-length payload after reset, with starts pulsed while busy.
        tx0 = tx_total; rd0 = rd_total;
        start_frame(0, 1'b0);
        repeat (20) @(posedge i_clk);
        #1 i_start = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_start = 1'b0;
        wait_frames(6);
        chk("z_tx_cycles", 32'(tx_total - tx0), 32'd72);
        chk("z_pl_rd", 32'(rd_total - rd0), 32'd0);
        chk("z_ip_id_after_rst", 32'(rx16(26)), 32'h0000);
        chk("z_ip_len", 32'(rx16(24)), 32'h001C);
        acc = 8'h00;
        for (int i = 50; i < 68; i++) acc = acc | last_frm[i];
        chk("z_pad18_zero", 32'(acc), 32'h0);
        chk("z_fcs_residue", residue(), 32'hDEBB20E3);
        wait_idle();
        tx0 = tx_total;
        repeat (30) @(posedge i_clk);
        chk("z_no_extra_frame", 32'(tx_total - tx0), 32'h0);
        chk("z_frames_total", 32'(frames_done), 32'd6);
        chk("z_model_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
